// File: rtl/axis_packet_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-level round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for a port count; never narrower than one bit.
  function automatic int id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/axis_packet_rr_arbiter_if.sv
// Bundles the requester-side and merged-output AXI-Stream signals of the arbiter.
interface axis_packet_rr_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int ID_WIDTH    = id_width(NUM_PORTS)
);

  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_axis_tdata;
  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_axis_tkeep;
  logic [NUM_PORTS-1:0]                 s_axis_tlast;
  logic [NUM_PORTS-1:0]                 s_axis_tvalid;
  logic [NUM_PORTS-1:0]                 s_axis_tready;

  logic [TDATA_WIDTH-1:0]               m_axis_tdata;
  logic [TDATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic                                 m_axis_tlast;
  logic [ID_WIDTH-1:0]                  m_axis_tid;
  logic                                 m_axis_tvalid;
  logic                                 m_axis_tready;

  logic                                 busy;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
    input  m_axis_tready,
    output busy
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
    output m_axis_tready,
    input  busy
  );

endinterface

// File: rtl/axis_packet_rr_arbiter_select.sv
// Combinational round-robin pick: first requester after last_grant, with wrap-around.
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  last_grant,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [ID_WIDTH-1:0]  grant_idx
);

  logic                found_s;
  logic [ID_WIDTH-1:0] cand_s;

  // Scan offsets 1..NUM_PORTS so last_grant itself is considered last.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found_s      = 1'b0;
    cand_s       = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand_s = ID_WIDTH'((32'(last_grant) + 32'(off)) % 32'(NUM_PORTS));
      if (!found_s && req[cand_s]) begin
        found_s              = 1'b1;
        grant_idx            = cand_s;
        grant_onehot[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS AXI-Stream sources onto one registered output.
module axis_packet_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int ID_WIDTH    = id_width(NUM_PORTS)
) (
  input  logic                        s_aclk,
  input  logic                        s_aresetn,
  axis_packet_rr_arbiter_if.slave     bus
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

  arb_state_e              state_r;
  arb_state_e              state_s;
  logic [ID_WIDTH-1:0]     grant_r;
  logic [ID_WIDTH-1:0]     grant_s;
  logic [ID_WIDTH-1:0]     last_grant_r;
  logic [ID_WIDTH-1:0]     last_grant_s;

  logic [NUM_PORTS-1:0]    sel_onehot_s;
  logic [ID_WIDTH-1:0]     sel_idx_s;
  logic                    any_req_s;

  logic                    out_free_s;
  logic                    accept_s;
  logic [NUM_PORTS-1:0]    ready_s;
  logic [TDATA_WIDTH-1:0]  beat_data_s;
  logic [KEEP_WIDTH-1:0]   beat_keep_s;
  logic                    beat_last_s;

  logic [TDATA_WIDTH-1:0]  m_tdata_r;
  logic [KEEP_WIDTH-1:0]   m_tkeep_r;
  logic                    m_tlast_r;
  logic [ID_WIDTH-1:0]     m_tid_r;
  logic                    m_tvalid_r;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_select (
    .req          (bus.s_axis_tvalid),
    .last_grant   (last_grant_r),
    .grant_onehot (sel_onehot_s),
    .grant_idx    (sel_idx_s)
  );

  assign any_req_s  = |sel_onehot_s;
  assign out_free_s = !m_tvalid_r || bus.m_axis_tready;

  // Steer the granted port's beat toward the output register.
  always_comb begin
    beat_data_s = bus.s_axis_tdata[32'(grant_r) * TDATA_WIDTH +: TDATA_WIDTH];
    beat_keep_s = bus.s_axis_tkeep[32'(grant_r) * KEEP_WIDTH +: KEEP_WIDTH];
    beat_last_s = bus.s_axis_tlast[grant_r];
  end

  // Only the owner of the grant sees ready, and only when the output slot can take a beat.
  always_comb begin
    ready_s = '0;
    if ((state_r == BUSY) && out_free_s) begin
      ready_s[grant_r] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s = (state_r == BUSY) && bus.s_axis_tvalid[grant_r] && out_free_s;

  // Next-state logic: grant is taken in IDLE and released on the accepted tlast beat.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s      = BUSY;
          grant_s      = sel_idx_s;
          last_grant_s = sel_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (accept_s && beat_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and grant registers; last_grant starts at the top port so port 0 wins first.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Output slot: a new beat wins over a drain, otherwise a drained beat clears valid.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      m_tdata_r  <= '0;
      m_tkeep_r  <= '0;
      m_tlast_r  <= 1'b0;
      m_tid_r    <= '0;
      m_tvalid_r <= 1'b0;
    end else if (accept_s) begin
      m_tdata_r  <= beat_data_s;
      m_tkeep_r  <= beat_keep_s;
      m_tlast_r  <= beat_last_s;
      m_tid_r    <= grant_r;
      m_tvalid_r <= 1'b1;
    end else if (m_tvalid_r && bus.m_axis_tready) begin
      m_tvalid_r <= 1'b0;
    end
  end

  assign bus.s_axis_tready = ready_s;
  assign bus.m_axis_tdata  = m_tdata_r;
  assign bus.m_axis_tkeep  = m_tkeep_r;
  assign bus.m_axis_tlast  = m_tlast_r;
  assign bus.m_axis_tid    = m_tid_r;
  assign bus.m_axis_tvalid = m_tvalid_r;
  assign bus.busy          = (state_r == BUSY);

endmodule

// File: doc/axis_packet_rr_arbiter.md
# axis_packet_rr_arbiter

Packet-level round-robin arbiter that merges NUM_PORTS AXI-Stream requesters onto one AXI-Stream output. It is placed directly in front of the shared 512-bit AXIS FIFO so that several producers (UDP TX sources) can share one FIFO. A grant is held from a packet's first beat until its tlast beat, so packets are never interleaved. A one-stage registered output decouples timing toward the FIFO.

## Interface
- NUM_PORTS, 4: number of requesters; legal values are 2 to 16.
- TDATA_WIDTH, 512: data width in bits; must be a multiple of 8.
- ID_WIDTH, $clog2(NUM_PORTS): width of the source-index field.

- s_aclk  input  1: the single clock for all logic.
- s_aresetn  input  1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is sampled on s_aclk.
- s_axis_tdata  input  NUM_PORTS*TDATA_WIDTH: requester data; port i occupies slice i.
- s_axis_tkeep  input  NUM_PORTS*TDATA_WIDTH/8: requester byte qualifiers, sliced per port.
- s_axis_tlast  input  NUM_PORTS: end-of-packet flag, one bit per port.
- s_axis_tvalid  input  NUM_PORTS: valid, one bit per port.
- s_axis_tready  output  NUM_PORTS: ready, one bit per port; at most one bit is high in any cycle.
- m_axis_tdata  output  TDATA_WIDTH: registered output data.
- m_axis_tkeep  output  TDATA_WIDTH/8: registered output byte qualifiers.
- m_axis_tlast  output  1: registered output end-of-packet flag.
- m_axis_tid  output  ID_WIDTH: index of the port that sourced the current beat.
- m_axis_tvalid  output  1: registered output valid.
- m_axis_tready  input  1: ready from the downstream FIFO.
- busy  output  1: high while the block is in state BUSY.

## Operation
- States:
  - IDLE: no grant is held.
  - BUSY: grant register g holds the index of the port that owns the output.
- IDLE, if any s_axis_tvalid bit is high:
  - select the first requesting port searching from (last_grant+1) mod NUM_PORTS upward, with wrap-around;
  - load g and last_grant with that port;
  - move to BUSY.
- IDLE, if no port is requesting: stay in IDLE. All s_axis_tready bits are 0 in IDLE.
- BUSY ready: s_axis_tready[g] = !m_axis_tvalid || m_axis_tready. All other ready bits are 0.
- BUSY accept: on s_axis_tvalid[g] && s_axis_tready[g], load slice g of tdata/tkeep/tlast into the output register, set m_axis_tid = g, and set m_axis_tvalid = 1.
- BUSY exit: if the accepted beat has tlast = 1, return to IDLE on the same edge.
- BUSY with s_axis_tvalid[g] low mid-packet: hold the grant indefinitely. There is no timeout and no pre-emption.
- Output register clear: when m_axis_tvalid && m_axis_tready and no new beat is loaded on that edge, m_axis_tvalid goes to 0.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep, tlast and tid are held stable.
- last_grant resets to NUM_PORTS-1, so port 0 has first priority after reset.
- Requesters that drop tvalid while in IDLE are simply not selected. The arbiter does not latch requests.

## Timing
- Reset values:
  - m_axis_tvalid, m_axis_tlast, busy: 0;
  - m_axis_tdata, m_axis_tkeep, m_axis_tid: all zeros;
  - s_axis_tready: all zeros;
  - state: IDLE; g: 0; last_grant: NUM_PORTS-1.
- Reset asserted mid-packet: all of the above values apply immediately. Any partial packet already accepted is lost. The upstream source must restart the packet after reset.
- Grant latency: requester tvalid rises in IDLE at cycle N → BUSY at N+1, with s_axis_tready[g]=1 at N+1 if the output register is free.
- Data latency: a beat accepted at edge E appears on the output with m_axis_tvalid=1 at E+1.
- Throughput within a packet: one beat per cycle under continuous tvalid and m_axis_tready.
- Packet gap: one IDLE cycle between consecutive packets, from the same port or different ports. Peak efficiency is L/(L+1) for L-beat packets.
- Single-beat packet (tlast on the first beat): BUSY for exactly one cycle.
- Simultaneous output drain and new accept in the same cycle: the new beat overwrites the register and m_axis_tvalid stays 1.

## Structure
- A shared package axis_arb_pkg holds:
  - the arbiter state enum (IDLE, BUSY);
  - the function for ID_WIDTH.
- Sub-module rr_priority_select (combinational): inputs are the request vector and last_grant; outputs are a one-hot grant and the grant index.
- The top level holds the FSM, the grant registers, the input mux and the output register.

## Test plan
- Reset mid-packet: assert s_aresetn=0 during beat 2 of a 4-beat packet → all outputs return to zero immediately; after release, port 0 is granted first.
- All four ports each present one 3-beat packet at once, m_axis_tready=1 → output order is tid 0,1,2,3; each packet takes 3 beats, followed by 1 idle cycle.
- Port 2 streams continuously: 5 packets of 2 beats → each packet is followed by exactly 1 bubble cycle; all m_axis_tid=2.
- Backpressure: hold m_axis_tready=0 for 4 cycles mid-packet → tdata, tkeep, tlast and tid are stable and s_axis_tready[g]=0. On release, beats continue without loss or duplication.
- Fairness after grant: port 1 finishes a packet while ports 0 and 3 are requesting → port 3 is granted next, then port 0.
- Granted port 1 drops tvalid for 6 cycles mid-packet while port 0 requests → the grant stays on port 1 and port 0 sees tready=0 throughout. The packet then completes intact with tkeep=0x0000_000F on its last beat.
